// File: rtl/pin_router.sv
// Routes core pin groups to one of NUM_PORTS pad banks each, with per-group break-before-make gap and park.
// Outputs are combinational from registered state; define PIN_ROUTER_SYNC_EN for 2-flop pad input synchronisers.
module pin_router #(
  parameter int   NUM_GROUPS = 4,
  parameter int   GROUP_W    = 8,
  parameter int   NUM_PORTS  = 2,
  parameter int   GAP_CYCLES = 4,
  parameter int   RESET_SEL  = 0,
  parameter logic IDLE_IN    = 1'b1,
  localparam int  SELW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int  N          = NUM_GROUPS * GROUP_W,
  localparam int  PW         = NUM_GROUPS * NUM_PORTS * GROUP_W
) (
  input  logic                       clk_cog,
  input  logic                       nres,
  input  logic [NUM_GROUPS*SELW-1:0] sel,
  input  logic [N-1:0]               pin_out,
  input  logic [N-1:0]               pin_dir,
  output logic [N-1:0]               pin_in,
  input  logic [PW-1:0]              port_in,
  output logic [PW-1:0]              port_out,
  output logic [PW-1:0]              port_oe,
  output logic [NUM_GROUPS-1:0]      busy
);

  localparam int CNTW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNTW-1:0] GAP_LAST = CNTW'(GAP_CYCLES - 1);
  localparam logic [SELW-1:0] SEL_RST  = SELW'(RESET_SEL);

  generate
    if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("pin_router: GAP_CYCLES must be at least 1");
    end
    if (NUM_PORTS < 2) begin : g_bad_ports
      $error("pin_router: NUM_PORTS must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {ST_ACTIVE, ST_GAP, ST_PARK} state_t;

  state_t                     r_state [NUM_GROUPS];
  logic [SELW-1:0]            r_cur   [NUM_GROUPS];
  logic [SELW-1:0]            r_tgt   [NUM_GROUPS];
  logic [CNTW-1:0]            r_cnt   [NUM_GROUPS];
  logic [NUM_GROUPS*SELW-1:0] r_sel_q;
  logic [NUM_GROUPS-1:0]      r_busy;

  logic [SELW-1:0]       w_req    [NUM_GROUPS];
  logic [NUM_GROUPS-1:0] w_req_ok;
  logic [PW-1:0]         w_src;
  logic [N-1:0]          w_ext;

  always_comb begin
    w_req_ok = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      w_req[g]    = r_sel_q[g*SELW +: SELW];
      w_req_ok[g] = (int'(w_req[g]) < NUM_PORTS);
    end
  end

  // busy is registered alongside the state so it never glitches on decode
  always_ff @(posedge clk_cog) begin
    if (!nres) begin
      r_sel_q <= {NUM_GROUPS{SEL_RST}};
      r_busy  <= '0;
      for (int g = 0; g < NUM_GROUPS; g++) begin
        r_state[g] <= ST_ACTIVE;
        r_cur[g]   <= SEL_RST;
        r_tgt[g]   <= SEL_RST;
        r_cnt[g]   <= '0;
      end
    end else begin
      r_sel_q <= sel;
      for (int g = 0; g < NUM_GROUPS; g++) begin
        case (r_state[g])
          ST_ACTIVE: begin
            if (w_req[g] != r_cur[g]) begin
              r_busy[g] <= 1'b1;
              if (w_req_ok[g]) begin
                r_state[g] <= ST_GAP;
                r_tgt[g]   <= w_req[g];
                r_cnt[g]   <= GAP_LAST;
              end else begin
                r_state[g] <= ST_PARK;
              end
            end
          end
          ST_GAP: begin
            if (w_req[g] != r_tgt[g]) begin
              if (w_req_ok[g]) begin
                r_tgt[g] <= w_req[g];
                r_cnt[g] <= GAP_LAST;
              end else begin
                r_state[g] <= ST_PARK;
              end
            end else if (r_cnt[g] == '0) begin
              r_state[g] <= ST_ACTIVE;
              r_cur[g]   <= r_tgt[g];
              r_busy[g]  <= 1'b0;
            end else begin
              r_cnt[g] <= r_cnt[g] - CNTW'(1);
            end
          end
          ST_PARK: begin
            // leaving park always goes through a full gap
            if (w_req_ok[g]) begin
              r_state[g] <= ST_GAP;
              r_tgt[g]   <= w_req[g];
              r_cnt[g]   <= GAP_LAST;
            end
          end
          default: begin
            r_state[g] <= ST_PARK;
            r_busy[g]  <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef PIN_ROUTER_SYNC_EN
  logic [PW-1:0] r_sync1;
  logic [PW-1:0] r_sync2;

  always_ff @(posedge clk_cog) begin
    if (!nres) begin
      r_sync1 <= {PW{IDLE_IN}};
      r_sync2 <= {PW{IDLE_IN}};
    end else begin
      r_sync1 <= port_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = port_in;
`endif

  always_comb begin
    port_out = '0;
    port_oe  = '0;
    w_ext    = {N{IDLE_IN}};
    for (int g = 0; g < NUM_GROUPS; g++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (r_state[g] == ST_ACTIVE && r_cur[g] == SELW'(p)) begin
          port_out[(g*NUM_PORTS+p)*GROUP_W +: GROUP_W] = pin_out[g*GROUP_W +: GROUP_W];
          port_oe [(g*NUM_PORTS+p)*GROUP_W +: GROUP_W] = pin_dir[g*GROUP_W +: GROUP_W];
          w_ext[g*GROUP_W +: GROUP_W] = w_src[(g*NUM_PORTS+p)*GROUP_W +: GROUP_W];
        end
      end
    end
  end

  // output bits read back the core's own drive value instead of the pad
  assign pin_in = (pin_dir & pin_out) | (~pin_dir & w_ext);
  assign busy   = r_busy;

endmodule
